// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default bit timing and frame constants
// used by both the receive and transmit paths of the monitor UART.
package uart_pkg;

    localparam int BIT_CNT_DEF  = 227;
    localparam int HALF_CNT_DEF = BIT_CNT_DEF / 2;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    typedef enum logic [2:0] {
        RX_IDLE      = ST_IDLE,
        RX_START     = ST_START,
        RX_DATA      = ST_DATA,
        RX_STOP      = ST_STOP,
        RX_WAIT_HIGH = ST_WAIT_HIGH
    } rx_state_e;

endpackage

// File: rtl/uart_rx_bittm.sv
// Bit-period timer: free-running 8-bit counter that ticks and wraps when it
// reaches the terminal value, or restarts from zero when cleared.
module uart_rx_bittm (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic [7:0] term_i,
    output logic       tick_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign tick_o = (cnt_q == term_i);

    always_comb begin
        cnt_d = cnt_q + 8'd1;
        if (clr_i || tick_o) begin
            cnt_d = 8'd0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of its inputs regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes the pin, samples each bit at mid-period and
// hands the byte to the consumer through a valid/acknowledge handshake.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BIT_CNT  = BIT_CNT_DEF,
    parameter int HALF_CNT = BIT_CNT / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_vld,
    input  logic       rx_ack,
    output logic       rx_ferr,
    output logic       rx_ovr,
    output logic       rx_busy
);

    localparam logic [7:0] BIT_TERM  = 8'(BIT_CNT - 1);
    localparam logic [7:0] HALF_TERM = 8'(HALF_CNT - 1);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

    rx_state_e  state_q, state_d;
    logic       rxd_meta_q, rxd_s_q;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_vld_q, rx_vld_d;
    logic       rx_ferr_q, rx_ferr_d;
    logic       rx_ovr_q, rx_ovr_d;

    logic       tm_clr;
    logic [7:0] tm_term;
    logic       tm_tick;

    // The timer restarts on every state change and idles at zero while waiting for the line.
    assign tm_clr  = (state_d != state_q) || (state_q == RX_IDLE) || (state_q == RX_WAIT_HIGH);
    assign tm_term = (state_q == RX_START) ? HALF_TERM : BIT_TERM;

    uart_rx_bittm u_bittm (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (tm_clr),
        .term_i (tm_term),
        .tick_o (tm_tick)
    );

    // NOTE: every variable gets a default before the case statement, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        rx_data_d = rx_data_q;
        rx_vld_d  = rx_vld_q;
        rx_ferr_d = 1'b0;
        rx_ovr_d  = 1'b0;

        if (rx_ack && rx_vld_q) begin
            rx_vld_d = 1'b0;
        end

        case (state_q)
            RX_IDLE: begin
                if (!rxd_s_q) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (tm_tick) begin
                    if (rxd_s_q) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d   = RX_DATA;
                        bit_idx_d = 3'd0;
                    end
                end
            end
            RX_DATA: begin
                if (tm_tick) begin
                    shift_d   = {rxd_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (tm_tick) begin
                    if (rxd_s_q) begin
                        state_d = RX_IDLE;
                        // A same-cycle ack frees the holding register for the new byte.
                        if (!rx_vld_q || rx_ack) begin
                            rx_data_d = shift_q;
                            rx_vld_d  = 1'b1;
                        end else begin
                            rx_ovr_d = 1'b1;
                        end
                    end else begin
                        rx_ferr_d = 1'b1;
                        state_d   = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                if (rxd_s_q) begin
                    state_d = RX_IDLE;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RX_IDLE;
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
            shift_q    <= 8'h00;
            bit_idx_q  <= 3'd0;
            rx_data_q  <= 8'h00;
            rx_vld_q   <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_ovr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rxd_meta_q <= uart_rxd;
            rxd_s_q    <= rxd_meta_q;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            rx_data_q  <= rx_data_d;
            rx_vld_q   <= rx_vld_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_ovr_q   <= rx_ovr_d;
        end
    end

    assign rx_data = rx_data_q;
    assign rx_vld  = rx_vld_q;
    assign rx_ferr = rx_ferr_q;
    assign rx_ovr  = rx_ovr_q;
    assign rx_busy = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames
// checked against a byte-level model of the receive handshake.
module tb_uart_rx;

    localparam int BIT  = 227;
    localparam int HALF = 113;
    localparam int LAT  = 2159;

    logic       clk;
    logic       rst;
    logic       uart_rxd;
    logic [7:0] rx_data;
    logic       rx_vld;
    logic       rx_ack;
    logic       rx_ferr;
    logic       rx_ovr;
    logic       rx_busy;

    uart_rx dut (
        .clk      (clk),
        .rst      (rst),
        .uart_rxd (uart_rxd),
        .rx_data  (rx_data),
        .rx_vld   (rx_vld),
        .rx_ack   (rx_ack),
        .rx_ferr  (rx_ferr),
        .rx_ovr   (rx_ovr),
        .rx_busy  (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    int   vld_rises    = 0;
    int   vld_rise_cyc = 0;
    int   ferr_cnt     = 0;
    int   ovr_cnt      = 0;
    int   busy_cyc     = 0;
    int   flag_viol    = 0;
    logic prev_vld = 1'b0, prev_ferr = 1'b0, prev_ovr = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_vld  = 1'b0;
            prev_ferr = 1'b0;
            prev_ovr  = 1'b0;
        end else begin
            if (rx_vld && !prev_vld) begin
                vld_rises++;
                vld_rise_cyc = cyc;
            end
            if (rx_ferr) ferr_cnt++;
            if (rx_ovr) ovr_cnt++;
            if (rx_busy) busy_cyc++;
            if ((rx_ferr && rx_ovr) || (rx_ferr && prev_ferr) || (rx_ovr && prev_ovr)) flag_viol++;
            prev_vld  = rx_vld;
            prev_ferr = rx_ferr;
            prev_ovr  = rx_ovr;
        end
    end

    int fall_cyc = 0;

    // Callers are positioned just after a falling edge; the line is left at the stop-bit level.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rxd = bits[i];
            if (i == 0) fall_cyc = cyc;
            repeat (BIT) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        #1;
    endtask

    int         v0, f0, o0, b0;
    logic [7:0] exp_data;
    logic       exp_vld;

    initial begin
        rst      = 1'b1;
        uart_rxd = 1'b1;
        rx_ack   = 1'b0;
        idle(3);
        check("rst_data", rx_data, 8'h00);
        check("rst_vld", rx_vld, 0);
        check("rst_ferr", rx_ferr, 0);
        check("rst_ovr", rx_ovr, 0);
        check("rst_busy", rx_busy, 0);
        rst = 1'b0;
        idle(5);

        // Single byte with latency measurement.
        v0 = vld_rises; f0 = ferr_cnt; o0 = ovr_cnt;
        send_frame(8'h55, 1'b1);
        idle(2);
        check("single_data", rx_data, 8'h55);
        check("single_vld", rx_vld, 1);
        check("single_rise", vld_rises - v0, 1);
        check("single_lat", (vld_rise_cyc - fall_cyc >= LAT - 1) && (vld_rise_cyc - fall_cyc <= LAT + 1), 1);
        check("single_flags", (ferr_cnt - f0) + (ovr_cnt - o0), 0);
        pulse_ack();
        check("ack_clear", rx_vld, 0);
        pulse_ack();
        check("ack_ignored", rx_vld, 0);
        idle(5);

        // Glitch rejection.
        v0 = vld_rises; b0 = busy_cyc;
        uart_rxd = 1'b0;
        idle(50);
        uart_rxd = 1'b1;
        idle(300);
        check("glitch_busy_window", (busy_cyc - b0 >= HALF - 1) && (busy_cyc - b0 <= HALF + 1), 1);
        check("glitch_vld", rx_vld, 0);
        check("glitch_rise", vld_rises - v0, 0);
        check("glitch_idle", rx_busy, 0);

        // Framing error followed by a stuck-low line.
        f0 = ferr_cnt; v0 = vld_rises;
        send_frame(8'hA3, 1'b0);
        idle(1000);
        check("ferr_count", ferr_cnt - f0, 1);
        check("ferr_vld", rx_vld, 0);
        check("ferr_rise", vld_rises - v0, 0);
        check("ferr_busy_low", rx_busy, 1);
        uart_rxd = 1'b1;
        idle(5);
        check("ferr_busy_released", rx_busy, 0);

        // Overrun: two back-to-back frames, no ack.
        o0 = ovr_cnt;
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        idle(2);
        check("ovr_data", rx_data, 8'h12);
        check("ovr_vld", rx_vld, 1);
        check("ovr_count", ovr_cnt - o0, 1);

        // Ack in the stop-sample cycle of 0x34 while 0x12 is pending.
        o0 = ovr_cnt;
        fork
            send_frame(8'h34, 1'b1);
            begin
                repeat (LAT - 1) @(negedge clk);
                rx_ack = 1'b1;
                @(negedge clk);
                rx_ack = 1'b0;
            end
        join
        idle(2);
        check("coll_data", rx_data, 8'h34);
        check("coll_vld", rx_vld, 1);
        check("coll_ovr", ovr_cnt - o0, 0);
        pulse_ack();
        check("coll_ack_clear", rx_vld, 0);
        idle(10);

        // Randomized frames against a byte-level handshake model.
        exp_data = 8'h34;
        exp_vld  = 1'b0;
        for (int n = 0; n < 6; n++) begin
            logic [7:0] b;
            logic       stop;
            logic       ack_after;
            int         exp_ferr, exp_ovr;
            b         = 8'($urandom);
            stop      = ($urandom_range(0, 4) != 0);
            ack_after = 1'($urandom_range(0, 1));
            f0 = ferr_cnt; o0 = ovr_cnt;
            exp_ferr = 0;
            exp_ovr  = 0;
            send_frame(b, stop);
            uart_rxd = 1'b1;
            idle(2);
            if (!stop) begin
                exp_ferr = 1;
            end else if (exp_vld) begin
                exp_ovr = 1;
            end else begin
                exp_data = b;
                exp_vld  = 1'b1;
            end
            check("rnd_data", rx_data, exp_data);
            check("rnd_vld", rx_vld, exp_vld);
            check("rnd_ferr", ferr_cnt - f0, exp_ferr);
            check("rnd_ovr", ovr_cnt - o0, exp_ovr);
            if (ack_after) begin
                pulse_ack();
                exp_vld = 1'b0;
                check("rnd_ack", rx_vld, 0);
            end
            idle($urandom_range(4, 200));
        end

        // Reset during data bit 4 of 0xFF, then a clean 0x0F.
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (5 * BIT + 100) @(negedge clk);
                rst = 1'b1;
                repeat (3) @(negedge clk);
                rst = 1'b0;
            end
        join
        idle(2);
        check("midrst_data", rx_data, 8'h00);
        check("midrst_vld", rx_vld, 0);
        check("midrst_busy", rx_busy, 0);
        v0 = vld_rises; f0 = ferr_cnt; o0 = ovr_cnt;
        send_frame(8'h0F, 1'b1);
        idle(2);
        check("post_rst_data", rx_data, 8'h0F);
        check("post_rst_rise", vld_rises - v0, 1);
        check("post_rst_flags", (ferr_cnt - f0) + (ovr_cnt - o0), 0);

        check("flag_exclusive", flag_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
